direction_scheduler: RTL and testbench

Sequences snake heading changes between the keypad edge detector and the game-step logic. Accepts one-cycle direction requests, filters illegal 180° reversals and redundant repeats, buffers legal requests in a small FIFO, and applies exactly one buffered request per game tick. Generates the game-tick pulse itself from a cycle counter, and implements idle, pause and game-over sequencing.

---
 rtl/direction_scheduler_if.sv | 29 ++
 rtl/direction_scheduler.sv | 150 +++++++++++++++
 tb/tb_direction_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/direction_scheduler_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | direction_scheduler_if                                                      |
// | Request/heading bundle between keypad logic, scheduler and game-step logic. |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
interface direction_scheduler_if #(
    parameter int DEPTH = 4
);
    logic                   dirValid;
    logic [1:0]             dirIn;
    logic                   pause;
    logic                   gameOver;
    logic [1:0]             snakeDirection;
    logic                   step;
    logic [$clog2(DEPTH):0] queueCount;
    logic                   dropped;

    modport master (
        output dirValid, dirIn, pause, gameOver,
        input  snakeDirection, step, queueCount, dropped
    );

    modport slave (
        input  dirValid, dirIn, pause, gameOver,
        output snakeDirection, step, queueCount, dropped
    );
endinterface
`default_nettype wire

// File: rtl/direction_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | direction_scheduler                                                         |
// | Filters heading requests, buffers them and applies one per game tick.       |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module direction_scheduler #(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int DEPTH       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    direction_scheduler_if.slave bus
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] C_FULL      = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_tick;
    logic [1:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [1:0]      r_dir;
    logic            r_step;
    logic            r_dropped;

    logic            w_halt_entry;
    logic            w_flush;
    logic            w_wrap;
    logic            w_pop;
    logic            w_full;
    logic [1:0]      w_ref;
    logic            w_reject;
    logic            w_push;

    // gameOver takes priority: no step or pop on the edge that enters HALT
    assign w_halt_entry = bus.gameOver && (r_state != S_IDLE);
    assign w_flush      = w_halt_entry || (r_state == S_HALT);
    assign w_wrap       = (r_state == S_RUN) && !bus.pause && !bus.gameOver
                          && (r_tick == C_TICK_LAST);
    assign w_pop        = w_wrap && (r_count != '0);
    assign w_full       = (r_count == C_FULL);

    // Reference heading is the newest queued entry, judged before any pop
    assign w_ref    = (r_count != '0) ? r_mem[r_wr_ptr - PW'(1)] : r_dir;
    assign w_reject = (bus.dirIn == (w_ref ^ 2'b10))
                   || (bus.dirIn == w_ref)
                   || (w_full && !w_pop)
                   || w_flush;
    assign w_push   = bus.dirValid && !w_reject;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.gameOver) begin
                    w_state_next = S_HALT;
                end else if (bus.pause) begin
                    w_state_next = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (bus.gameOver) begin
                    w_state_next = S_HALT;
                end else if (!bus.pause) begin
                    w_state_next = S_RUN;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_dir     <= 2'b00;
            r_step    <= 1'b0;
            r_dropped <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'b00;
            end
        end else begin
            r_step    <= w_wrap;
            r_dropped <= bus.dirValid && w_reject;
            if (w_flush) begin
                r_tick   <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                // Counting pauses on the same edge that pause is seen
                if ((r_state == S_RUN) && !bus.pause) begin
                    r_tick <= w_wrap ? '0 : r_tick + TW'(1);
                end
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.dirIn;
                    r_wr_ptr        <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_dir    <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    assign bus.snakeDirection = r_dir;
    assign bus.step           = r_step;
    assign bus.queueCount     = r_count;
    assign bus.dropped        = r_dropped;
endmodule
`default_nettype wire

// File: tb/tb_direction_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_direction_scheduler                                                      |
// | Directed scenarios plus random traffic against a queue-based model.         |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module tb_direction_scheduler;
    localparam int TICK_CYCLES = 4;
    localparam int DEPTH       = 4;
    localparam int QW          = $clog2(DEPTH) + 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_HALT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    direction_scheduler_if #(.DEPTH(DEPTH)) intf ();

    direction_scheduler #(
        .TICK_CYCLES (TICK_CYCLES),
        .DEPTH       (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;

    // Reference model: mode, tick count and a plain queue of pending headings
    int         m_mode = M_IDLE;
    int         m_cnt  = 0;
    logic [1:0] m_q[$];
    logic [1:0] m_dir  = 2'b00;
    logic       m_step = 1'b0;
    logic       m_drop = 1'b0;
    logic [1:0] m_ref;
    bit         m_stop, m_fire, m_ok;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_IDLE; m_cnt = 0; m_q.delete();
            m_dir = 2'b00; m_step = 1'b0; m_drop = 1'b0;
        end else begin
            m_stop = intf.gameOver && (m_mode != M_IDLE);
            m_fire = (m_mode == M_RUN) && !intf.pause && !m_stop && (m_cnt == TICK_CYCLES - 1);
            m_ref  = (m_q.size() > 0) ? m_q[$] : m_dir;
            m_ok   = intf.dirValid && (m_mode != M_HALT) && !m_stop
                     && (intf.dirIn != m_ref) && (intf.dirIn != (m_ref ^ 2'b10))
                     && ((m_q.size() < DEPTH) || m_fire);
            m_step = m_fire;
            m_drop = intf.dirValid && !m_ok;
            if (m_stop) begin
                m_mode = M_HALT; m_q.delete(); m_cnt = 0;
            end else begin
                if (m_fire && m_q.size() > 0) m_dir = m_q.pop_front();
                if (m_ok) m_q.push_back(intf.dirIn);
                if (m_mode == M_RUN && !intf.pause) m_cnt = (m_cnt + 1) % TICK_CYCLES;
                if (m_mode == M_IDLE && m_ok) m_mode = M_RUN;
                else if (m_mode == M_RUN && intf.pause) m_mode = M_PAUSED;
                else if (m_mode == M_PAUSED && !intf.pause) m_mode = M_RUN;
            end
        end
    end

    task automatic drive_req(input logic [1:0] d);
        intf.dirValid = 1'b1;
        intf.dirIn    = d;
        @(negedge clk);
        intf.dirValid = 1'b0;
    endtask

    task automatic wait_step(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (intf.step) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        int steps_seen;
        steps_seen = 0;
        reset = 1'b1;
        intf.dirValid = 1'b0; intf.dirIn = 2'b00; intf.pause = 1'b0; intf.gameOver = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({intf.snakeDirection, intf.step, intf.queueCount, intf.dropped} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: dir=%b step=%b count=%0d dropped=%b expected all zero",
                     intf.snakeDirection, intf.step, intf.queueCount, intf.dropped);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (intf.step) steps_seen++;
        end
        checks++;
        if (steps_seen !== 0) begin
            failures++; $display("FAIL idle_no_step: steps=%0d expected 0", steps_seen);
        end
        checks++;
        if (intf.snakeDirection !== 2'b00 || intf.queueCount !== QW'(0)) begin
            failures++;
            $display("FAIL idle_state: dir=%b count=%0d expected 00/0", intf.snakeDirection, intf.queueCount);
        end
    endtask

    task automatic test_first_request();
        drive_req(2'b01);
        checks++;
        if (intf.queueCount !== QW'(1) || intf.dropped !== 1'b0) begin
            failures++;
            $display("FAIL first_enqueue: count=%0d dropped=%b expected 1/0", intf.queueCount, intf.dropped);
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if (intf.step !== (i % 4 == 0)) begin
                failures++;
                $display("FAIL step_cadence_c%0d: step=%b expected %b", i, intf.step, (i % 4 == 0));
            end
            if (i % 4 == 0) begin
                checks++;
                if (intf.snakeDirection !== 2'b01 || intf.queueCount !== QW'(0)) begin
                    failures++;
                    $display("FAIL first_apply_c%0d: dir=%b count=%0d expected 01/0", i,
                             intf.snakeDirection, intf.queueCount);
                end
            end
        end
    endtask

    task automatic test_filter();
        bit found;
        drive_req(2'b11);
        checks++;
        if (intf.dropped !== 1'b1) begin
            failures++; $display("FAIL drop_reversal: dropped=%b expected 1", intf.dropped);
        end
        drive_req(2'b01);
        checks++;
        if (intf.dropped !== 1'b1) begin
            failures++; $display("FAIL drop_repeat: dropped=%b expected 1", intf.dropped);
        end
        drive_req(2'b00);
        checks++;
        if (intf.dropped !== 1'b0 || intf.queueCount !== QW'(1)) begin
            failures++;
            $display("FAIL accept_turn: dropped=%b count=%0d expected 0/1", intf.dropped, intf.queueCount);
        end
        wait_step(8, found);
        checks++;
        if (!found || intf.snakeDirection !== 2'b00 || intf.queueCount !== QW'(0)) begin
            failures++;
            $display("FAIL turn_applied: found=%b dir=%b count=%0d expected 1/00/0",
                     found, intf.snakeDirection, intf.queueCount);
        end
    endtask

    task automatic test_pause_full();
        bit         found;
        int         steps_seen;
        logic [1:0] exp_dirs [4];
        exp_dirs[0] = 2'b00; exp_dirs[1] = 2'b11; exp_dirs[2] = 2'b10; exp_dirs[3] = 2'b01;
        drive_req(2'b11);
        wait_step(8, found);
        checks++;
        if (!found || intf.snakeDirection !== 2'b11) begin
            failures++; $display("FAIL setup_right: found=%b dir=%b expected 1/11", found, intf.snakeDirection);
        end
        intf.pause = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            drive_req(exp_dirs[k]);
            checks++;
            if (intf.dropped !== 1'b0 || intf.queueCount !== QW'(k + 1)) begin
                failures++;
                $display("FAIL paused_push_%0d: dropped=%b count=%0d expected 0/%0d",
                         k, intf.dropped, intf.queueCount, k + 1);
            end
        end
        // 00 is neither a repeat nor a reversal of tail 01, so only fullness rejects it
        drive_req(2'b00);
        checks++;
        if (intf.dropped !== 1'b1 || intf.queueCount !== QW'(DEPTH)) begin
            failures++;
            $display("FAIL drop_full: dropped=%b count=%0d expected 1/%0d", intf.dropped, intf.queueCount, DEPTH);
        end
        steps_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (intf.step) steps_seen++;
        end
        checks++;
        if (steps_seen !== 0) begin
            failures++; $display("FAIL paused_no_step: steps=%0d expected 0", steps_seen);
        end
        intf.pause = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_step(12, found);
            checks++;
            if (!found || intf.snakeDirection !== exp_dirs[k]) begin
                failures++;
                $display("FAIL drain_order_%0d: found=%b dir=%b expected 1/%b", k, found,
                         intf.snakeDirection, exp_dirs[k]);
            end
        end
    endtask

    task automatic test_wrap_edges();
        bit         found;
        logic [1:0] fill [4];
        logic [1:0] exp_dirs [4];
        fill[0] = 2'b00; fill[1] = 2'b11; fill[2] = 2'b10; fill[3] = 2'b01;
        exp_dirs[0] = 2'b10; exp_dirs[1] = 2'b01; exp_dirs[2] = 2'b00; exp_dirs[3] = 2'b11;
        intf.pause = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) drive_req(fill[k]);
        checks++;
        if (intf.queueCount !== QW'(4)) begin
            failures++; $display("FAIL wrap_fill: count=%0d expected 4", intf.queueCount);
        end
        intf.pause = 1'b0;
        wait_step(16, found);
        checks++;
        if (!found || intf.snakeDirection !== 2'b00 || intf.queueCount !== QW'(3)) begin
            failures++;
            $display("FAIL wrap_first: found=%b dir=%b count=%0d expected 1/00/3",
                     found, intf.snakeDirection, intf.queueCount);
        end
        drive_req(2'b00);
        checks++;
        if (intf.queueCount !== QW'(4)) begin
            failures++; $display("FAIL wrap_refill: count=%0d expected 4", intf.queueCount);
        end
        repeat (2) @(negedge clk);
        drive_req(2'b11);
        checks++;
        if (intf.step !== 1'b1 || intf.snakeDirection !== 2'b11 || intf.queueCount !== QW'(4)
            || intf.dropped !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop: step=%b dir=%b count=%0d dropped=%b expected 1/11/4/0",
                     intf.step, intf.snakeDirection, intf.queueCount, intf.dropped);
        end
        for (int k = 0; k < 4; k++) begin
            wait_step(8, found);
            checks++;
            if (!found || intf.snakeDirection !== exp_dirs[k]) begin
                failures++;
                $display("FAIL wrap_drain_%0d: found=%b dir=%b expected 1/%b", k, found,
                         intf.snakeDirection, exp_dirs[k]);
            end
        end
        checks++;
        if (intf.queueCount !== QW'(0)) begin
            failures++; $display("FAIL wrap_empty: count=%0d expected 0", intf.queueCount);
        end
        repeat (3) @(negedge clk);
        drive_req(2'b00);
        checks++;
        if (intf.step !== 1'b1 || intf.snakeDirection !== 2'b11 || intf.queueCount !== QW'(1)) begin
            failures++;
            $display("FAIL no_bypass: step=%b dir=%b count=%0d expected 1/11/1",
                     intf.step, intf.snakeDirection, intf.queueCount);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (intf.step !== 1'b1 || intf.snakeDirection !== 2'b00 || intf.queueCount !== QW'(0)) begin
            failures++;
            $display("FAIL next_step_apply: step=%b dir=%b count=%0d expected 1/00/0",
                     intf.step, intf.snakeDirection, intf.queueCount);
        end
    endtask

    task automatic test_gameover();
        intf.pause = 1'b1;
        @(negedge clk);
        drive_req(2'b11);
        drive_req(2'b00);
        drive_req(2'b01);
        checks++;
        if (intf.queueCount !== QW'(3)) begin
            failures++; $display("FAIL halt_prefill: count=%0d expected 3", intf.queueCount);
        end
        intf.gameOver = 1'b1;
        @(negedge clk);
        intf.gameOver = 1'b0;
        intf.pause    = 1'b0;
        checks++;
        if (intf.queueCount !== QW'(0)) begin
            failures++; $display("FAIL halt_flush: count=%0d expected 0", intf.queueCount);
        end
        for (int i = 0; i < 12; i++) begin
            drive_req(2'($urandom_range(0, 3)));
            checks++;
            if (intf.dropped !== 1'b1 || intf.step !== 1'b0 || intf.queueCount !== QW'(0)) begin
                failures++;
                $display("FAIL halt_sticky_%0d: dropped=%b step=%b count=%0d expected 1/0/0",
                         i, intf.dropped, intf.step, intf.queueCount);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit found;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_req(2'b01);
        drive_req(2'b00);
        checks++;
        if (intf.queueCount !== QW'(2)) begin
            failures++; $display("FAIL midrun_fill: count=%0d expected 2", intf.queueCount);
        end
        wait_step(8, found);
        checks++;
        if (!found || intf.snakeDirection !== 2'b01 || intf.queueCount !== QW'(1)) begin
            failures++;
            $display("FAIL midrun_step: found=%b dir=%b count=%0d expected 1/01/1",
                     found, intf.snakeDirection, intf.queueCount);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({intf.snakeDirection, intf.step, intf.queueCount, intf.dropped} !== '0) begin
            failures++;
            $display("FAIL async_reset: dir=%b step=%b count=%0d dropped=%b expected all zero",
                     intf.snakeDirection, intf.step, intf.queueCount, intf.dropped);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            checks++;
            if (intf.step !== m_step) begin
                failures++; $display("FAIL rand_step_c%0d: step=%b expected %b", c, intf.step, m_step);
            end
            checks++;
            if (intf.snakeDirection !== m_dir) begin
                failures++; $display("FAIL rand_dir_c%0d: dir=%b expected %b", c, intf.snakeDirection, m_dir);
            end
            checks++;
            if (intf.queueCount !== QW'(m_q.size())) begin
                failures++;
                $display("FAIL rand_count_c%0d: count=%0d expected %0d", c, intf.queueCount, m_q.size());
            end
            checks++;
            if (intf.dropped !== m_drop) begin
                failures++; $display("FAIL rand_drop_c%0d: dropped=%b expected %b", c, intf.dropped, m_drop);
            end
            reset         = ($urandom_range(0, 119) == 0);
            intf.dirValid = ($urandom_range(0, 1) == 1);
            intf.dirIn    = 2'($urandom_range(0, 3));
            intf.gameOver = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 11) == 0) intf.pause = ~intf.pause;
        end
        reset = 1'b0; intf.dirValid = 1'b0; intf.gameOver = 1'b0; intf.pause = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_request();
        test_filter();
        test_pause_full();
        test_wrap_edges();
        test_gameover();
        test_reset_midrun();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
